mac_stream_driver: RTL

Upstream driver for the 10×10 saturating pipelined multiply-accumulate unit. It holds an N-pair operand buffer loaded by the host. On `start` it:
- clears the MAC accumulator,
- streams the operand pairs into the MAC's `a`/`b`/`valid_in` port,
- counts the returning `valid_out` pulses,
- latches the final accumulated `f` and raises `done`.

It is the producer/consumer at the other end of the MAC's valid_in/valid_out protocol.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_operand_buf.sv | 25 ++
 rtl/mac_stream_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC stream driver and its operand buffer.
package mac_pkg;
  localparam int OP_W  = 10;
  localparam int ACC_W = 20;

  localparam logic [ACC_W-1:0] ACC_MAX = 20'h7FFFF;
  localparam logic [ACC_W-1:0] ACC_MIN = 20'h80000;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} drv_state_t;

  function automatic logic is_sat(input logic [ACC_W-1:0] v);
    return (v == ACC_MAX) || (v == ACC_MIN);
  endfunction
endpackage

// File: rtl/mac_operand_buf.sv
// Operand pair store: one synchronous write port, one combinational read port.
module mac_operand_buf
  import mac_pkg::*;
#(
  parameter int N_PAIRS = 8,
  localparam int AW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [2*OP_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [2*OP_W-1:0] rd_data
);
  logic [2*OP_W-1:0] mem [N_PAIRS];

  // Addresses past the last pair (non power-of-two depth) are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < N_PAIRS)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/mac_stream_driver.sv
// Streams buffered operand pairs into the pipelined MAC, counts returns and
// captures the final accumulator; aborts with error if returns stop arriving.
module mac_stream_driver
  import mac_pkg::*;
#(
  parameter int N_PAIRS = 8,
  parameter int TIMEOUT = 16,
  localparam int AW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [OP_W-1:0]  load_a,
  input  logic [OP_W-1:0]  load_b,
  input  logic             start,
  input  logic             hold,
  output logic             mac_reset,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_valid_in,
  input  logic [ACC_W-1:0] mac_f,
  input  logic             mac_valid_out,
  output logic [ACC_W-1:0] result,
  output logic             saturated,
  output logic             done,
  output logic             error,
  output logic             busy
);
  localparam int CW = $clog2(N_PAIRS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  drv_state_t state_reg, state_next;

  logic [CW-1:0]     issue_cnt_reg, ret_cnt_reg;
  logic [TW-1:0]     to_cnt_reg;
  logic [ACC_W-1:0]  last_f_reg, result_reg;
  logic              sat_reg, error_reg, mac_reset_reg, mac_valid_reg;
  logic [OP_W-1:0]   mac_a_reg, mac_b_reg;
  logic [2*OP_W-1:0] rd_data;

  logic issue, last_issue, ret, all_back, timeout;

  mac_operand_buf #(.N_PAIRS(N_PAIRS)) u_buf (
    .clk     (clk),
    .wr_en   (load_en && (state_reg == IDLE)),
    .wr_addr (load_addr),
    .wr_data ({load_a, load_b}),
    .rd_addr (issue_cnt_reg[AW-1:0]),
    .rd_data (rd_data)
  );

  // The output register is loaded on the edge leaving CLEAR, so the first
  // pair is on the bus during the first STREAM cycle.
  always_comb begin
    issue      = ((state_reg == CLEAR) || (state_reg == STREAM)) && !hold;
    last_issue = issue && (issue_cnt_reg == CW'(N_PAIRS - 1));
    all_back   = (ret_cnt_reg == CW'(N_PAIRS));
    ret        = mac_valid_out && !all_back &&
                 ((state_reg == STREAM) || (state_reg == DRAIN));
    timeout    = (state_reg == DRAIN) && !all_back && !mac_valid_out &&
                 (to_cnt_reg == TW'(TIMEOUT - 1));
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = last_issue ? DRAIN : STREAM;
      STREAM:  if (last_issue) state_next = DRAIN;
      DRAIN:   if (all_back || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      to_cnt_reg    <= '0;
      last_f_reg    <= '0;
      result_reg    <= '0;
      sat_reg       <= 1'b0;
      error_reg     <= 1'b0;
      mac_reset_reg <= 1'b1;
      mac_valid_reg <= 1'b0;
      mac_a_reg     <= '0;
      mac_b_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      mac_reset_reg <= (state_next == CLEAR);

      if ((state_reg == IDLE) && start) begin
        error_reg     <= 1'b0;
        issue_cnt_reg <= '0;
        ret_cnt_reg   <= '0;
        to_cnt_reg    <= '0;
        last_f_reg    <= '0;
      end

      mac_valid_reg <= issue;
      if (issue) begin
        mac_a_reg     <= rd_data[2*OP_W-1:OP_W];
        mac_b_reg     <= rd_data[OP_W-1:0];
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
      end

      if (ret) begin
        ret_cnt_reg <= ret_cnt_reg + 1'b1;
        last_f_reg  <= mac_f;
      end

      if (mac_valid_out) begin
        to_cnt_reg <= '0;
      end else if (state_reg == DRAIN) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end

      if (timeout) error_reg <= 1'b1;

      // Publish the captured accumulator only as the run completes.
      if ((state_reg == DRAIN) && (state_next == DONE)) begin
        result_reg <= last_f_reg;
        sat_reg    <= is_sat(last_f_reg);
      end
    end
  end

  assign mac_reset    = mac_reset_reg;
  assign mac_a        = mac_a_reg;
  assign mac_b        = mac_b_reg;
  assign mac_valid_in = mac_valid_reg;
  assign result       = result_reg;
  assign saturated    = sat_reg;
  assign error        = error_reg;
  assign done         = (state_reg == DONE);
  assign busy         = (state_reg != IDLE);
endmodule
